// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bin2bcd_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} bin2bcd_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

  // ceil(width * log10(2)), using log10(2) ~= 0.30103 in fixed point
  function automatic int min_digits(input int width);
    return (width * 32'sd30103 + 32'sd99999) / 32'sd100000;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One BCD digit of the add-3 correction applied before every shift.
module bcd_dabble_digit
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Digits of 5 or more would exceed 9 after doubling, so pre-bias them by 3
  always_comb begin
    q = d;
    if (d >= BCD_ADJ_THRESH) begin
      q = d + 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, start/ready handshake.
// Optional BIN2BCD_SIGNED_EN: treat bin_in as two's complement and report the sign on neg.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  neg
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DIGITS < min_digits(WIDTH)) begin : g_narrow
    $info("bin2bcd_seq: DIGITS=%0d is below min_digits(%0d)=%0d, overflow is reachable",
          DIGITS, WIDTH, min_digits(WIDTH));
  end

  bin2bcd_state_t   state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [BW-1:0]    acc_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt_r;
  logic [BW-1:0]    adj_s;
  logic [BW-1:0]    acc_nxt_s;
  logic [WIDTH-1:0] shreg_nxt_s;
  logic             ovf_nxt_s;
  logic [WIDTH-1:0] operand_s;
`ifdef BIN2BCD_SIGNED_EN
  logic             neg_s;
  logic             neg_pend_r;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_dabble_digit u_digit (
      .d (acc_r[4*i +: 4]),
      .q (adj_s[4*i +: 4])
    );
  end

  // Operand loaded at accept; the signed build converts to magnitude so -2^(W-1) maps to 2^(W-1)
  always_comb begin
`ifdef BIN2BCD_SIGNED_EN
    neg_s     = bin_in[WIDTH-1];
    operand_s = neg_s ? (~bin_in + {{(WIDTH-1){1'b0}}, 1'b1}) : bin_in;
`else
    operand_s = bin_in;
`endif
  end

  // The carry out of the top digit is dropped from the accumulator, so it keeps value mod 10^DIGITS
  always_comb begin
    acc_nxt_s   = {adj_s[BW-2:0], shreg_r[WIDTH-1]};
    shreg_nxt_s = {shreg_r[WIDTH-2:0], 1'b0};
    ovf_nxt_s   = ovf_r | adj_s[BW-1];
  end

  assign ready = (state_r == IDLE);

  // Conversion FSM with registered result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      shreg_r    <= {WIDTH{1'b0}};
      acc_r      <= {BW{1'b0}};
      ovf_r      <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      done       <= 1'b0;
      bcd_out    <= {BW{1'b0}};
      overflow   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_r <= 1'b0;
      neg        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            shreg_r    <= operand_s;
            acc_r      <= {BW{1'b0}};
            ovf_r      <= 1'b0;
            cnt_r      <= CNT_INIT;
`ifdef BIN2BCD_SIGNED_EN
            neg_pend_r <= neg_s;
`endif
            state_r    <= SHIFT;
          end else begin
            state_r    <= IDLE;
          end
        end
        SHIFT: begin
          acc_r   <= acc_nxt_s;
          shreg_r <= shreg_nxt_s;
          ovf_r   <= ovf_nxt_s;
          cnt_r   <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            bcd_out  <= acc_nxt_s;
            overflow <= ovf_nxt_s;
            done     <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
            neg      <= neg_pend_r;
`endif
            state_r  <= IDLE;
          end else begin
            state_r  <= SHIFT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance, both WIDTH=8.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic [7:0]  bin_in = 8'd0, bin_in2 = 8'd0;
  logic        ready, done, overflow, ready2, done2, overflow2;
  logic [11:0] bcd_out;
  logic [7:0]  bcd_out2;
`ifdef BIN2BCD_SIGNED_EN
  logic        neg, neg2;
`endif

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    logic        ng;
    int          acc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   n_cmp = 0, n_err = 0, cyc = 0, dones = 0;
  int   done_t[$];

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .ready(ready), .done(done), .bcd_out(bcd_out), .overflow(overflow)
`ifdef BIN2BCD_SIGNED_EN
    , .neg(neg)
`endif
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .bin_in(bin_in2),
    .ready(ready2), .done(done2), .bcd_out(bcd_out2), .overflow(overflow2)
`ifdef BIN2BCD_SIGNED_EN
    , .neg(neg2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference by division: magnitude, digits mod 10^digits, overflow when it does not fit
  function automatic exp_t model(input logic [7:0] v, input int digits, input int acc);
    exp_t e;
    int m, pw, r;
    m = int'(v);
    e.ng = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (v[7]) begin
      m = 256 - int'(v);
      e.ng = 1'b1;
    end
`endif
    pw = 1;
    for (int i = 0; i < digits; i++) pw = pw * 10;
    e.ovf = (m >= pw);
    r = m % pw;
    e.bcd = 12'h000;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      dones++;
      done_t.push_back(cyc);
      if (q1.size() == 0) begin
        check_eq("dut unexpected done", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check_eq("dut bcd_out", 32'(bcd_out), 32'(e1.bcd));
        check_eq("dut overflow", 32'(overflow), 32'(e1.ovf));
        check_eq("dut latency", 32'(cyc - e1.acc), 32'd8);
        check_eq("dut ready in done cycle", 32'(ready), 32'd1);
`ifdef BIN2BCD_SIGNED_EN
        check_eq("dut neg", 32'(neg), 32'(e1.ng));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        check_eq("dut2 unexpected done", 32'd1, 32'd0);
      end else begin
        e2 = q2.pop_front();
        check_eq("dut2 bcd_out", 32'(bcd_out2), 32'(e2.bcd[7:0]));
        check_eq("dut2 overflow", 32'(overflow2), 32'(e2.ovf));
        check_eq("dut2 latency", 32'(cyc - e2.acc), 32'd8);
`ifdef BIN2BCD_SIGNED_EN
        check_eq("dut2 neg", 32'(neg2), 32'(e2.ng));
`endif
      end
    end
  end

  task automatic accept(input int which, input logic [7:0] v);
    int t;
    t = 0;
    while (((which == 1) ? !ready : !ready2) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check_eq("ready timeout", 32'd0, 32'd1);
    if (which == 1) begin start = 1'b1; bin_in = v; end
    else begin start2 = 1'b1; bin_in2 = v; end
    @(posedge clk); #1;
    if (which == 1) begin q1.push_back(model(v, 3, cyc)); start = 1'b0; end
    else begin q2.push_back(model(v, 2, cyc)); start2 = 1'b0; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) check_eq("drain timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int t, d0;
    #3;
    check_eq("reset ready", 32'(ready), 32'd1);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset bcd_out", 32'(bcd_out), 32'd0);
    check_eq("reset overflow", 32'(overflow), 32'd0);
    check_eq("reset ready2", 32'(ready2), 32'd1);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    accept(1, 8'd255); drain();
    accept(1, 8'd0);   drain();

    // start held through the done cycle: the second operand goes in on the very next edge
    done_t.delete();
    start = 1'b1; bin_in = 8'd123;
    @(posedge clk); #1;
    q1.push_back(model(8'd123, 3, cyc));
    t = 0;
    while (!done && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) check_eq("done wait timeout", 32'd0, 32'd1);
    bin_in = 8'd45;
    @(posedge clk); #1;
    q1.push_back(model(8'd45, 3, cyc));
    start = 1'b0;
    drain();
    if (done_t.size() >= 2) check_eq("done spacing", 32'(done_t[1] - done_t[0]), 32'd9);
    else check_eq("done pulse count", 32'(done_t.size()), 32'd2);

    d0 = dones;
    accept(1, 8'd77);
    start = 1'b1; bin_in = 8'd11;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    drain();
    check_eq("single done under busy start", 32'(dones - d0), 32'd1);

    accept(1, 8'd200);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midreset ready", 32'(ready), 32'd1);
    check_eq("midreset done", 32'(done), 32'd0);
    check_eq("midreset bcd_out", 32'(bcd_out), 32'd0);
    check_eq("midreset overflow", 32'(overflow), 32'd0);
    q1.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    accept(1, 8'd9); drain();

    accept(2, 8'd200); drain();
    accept(2, 8'd99);  drain();

`ifdef BIN2BCD_SIGNED_EN
    accept(1, 8'hD8); drain();
    accept(1, 8'h80); drain();
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble). It accepts a WIDTH-bit binary value through a start/ready handshake and produces DIGITS packed BCD digits plus an overflow flag after WIDTH clock cycles. It sits between arithmetic blocks, such as the temperature-conversion datapath, and the seven-segment display driver. It replaces purely combinational divide/modulo digit splitting for wide operands.

## Interface
- WIDTH, default 8: binary input width; legal range 4..32.
- DIGITS, default 3: number of BCD output digits; legal range 1..10.
- clk  input  1: rising-edge clock.
- reset_n  input  1: asynchronous, active-low reset.
- start  input  1: conversion request; accepted only while ready=1.
- bin_in  input  WIDTH: operand; sampled only on the accept edge.
- ready  output  1: high in IDLE; low while converting.
- done  output  1: one-cycle pulse when a result becomes valid.
- bcd_out  output  4*DIGITS: packed digits; digit i is at [4i+3:4i], with digit 0 = ones.
- overflow  output  1: result did not fit in DIGITS digits.
- neg  output  1: present only with BIN2BCD_SIGNED_EN; the input was negative.

## Operation
- States:
  - IDLE: ready=1.
    - On start=1 at a clock edge: load the shift register with bin_in (or its magnitude, see Configuration), clear the BCD accumulator and the overflow sticky bit, set the counter to WIDTH, and go to SHIFT.
  - SHIFT: ready=0.
    - Each edge: every accumulator digit ≥5 gets +3.
    - Then {accumulator, shift register} shifts left by 1.
    - The bit shifted out of the top digit ORs into the overflow sticky bit.
    - The counter decrements.
    - On the edge where the counter goes 1→0: register bcd_out and overflow, assert done for one cycle, and return to IDLE.
- No separate DONE state: done and ready=1 are high in the same cycle.
- start while ready=0 is ignored, with no queuing. bin_in changes during SHIFT have no effect.
- bcd_out, overflow and neg hold their last result until the next completion. They are not cleared on accept.
- On overflow, bcd_out = value mod 10^DIGITS, and overflow=1.
- Reset at any time, including mid-conversion: return to IDLE immediately. All outputs take reset values and the conversion in progress is discarded.

## Timing
- Reset values: ready=1, done=0, bcd_out=0, overflow=0, neg=0.
- Accept on edge k produces done=1 in the cycle after edge k+WIDTH. Latency is WIDTH cycles.
- start held high in the done cycle is accepted on edge k+WIDTH+1. Sustained throughput is one result per WIDTH+1 cycles.
- All outputs are registered, except ready, which is decoded from the state register.

## Configuration
- BIN2BCD_SIGNED_EN
  - Defined:
    - bin_in is two's complement.
    - At accept, neg takes bin_in[WIDTH-1] and the shift register takes |bin_in| as a WIDTH-bit unsigned value. −2^(WIDTH-1) maps to 2^(WIDTH-1).
    - neg updates together with bcd_out at completion.
  - Undefined:
    - bin_in is unsigned.
    - The neg port does not exist.

## Structure
- Package bin2bcd_pkg contains:
  - typedef enum logic {IDLE, SHIFT} bin2bcd_state_t.
  - A constant function min_digits(width), returning ceil(width·log10 2). It is used in an elaboration-time warning when DIGITS < min_digits(WIDTH).
  - The constant BCD_ADJ_THRESH = 4'd5.
- Sub-module bcd_dabble_digit: a combinational 4-bit input that outputs (d ≥ 5) ? d+3 : d. The accumulator instantiates it DIGITS times in a generate loop.

## Test plan
- WIDTH=8, DIGITS=3: bin_in=255 -> done 8 cycles after accept, bcd_out=12'h255, overflow=0.
- bin_in=0 -> bcd_out=12'h000. Then bin_in=123 with start held high through the done cycle, then bin_in=45 -> results 12'h123 and 12'h045, with done pulses exactly 9 cycles apart.
- WIDTH=8, DIGITS=2: bin_in=200 -> bcd_out=8'h00, overflow=1. bin_in=99 -> 8'h99, overflow=0.
- start with bin_in=77 at accept, then start=1 with bin_in=11 on the next 3 cycles -> only one done, and bcd_out=12'h077.
- Accept 200, then drop reset_n on cycle 4 -> outputs are 0 and ready=1 immediately. After release, accept 9 -> 12'h009.
- BIN2BCD_SIGNED_EN, WIDTH=8: bin_in=8'hD8 (−40) -> neg=1, bcd_out=12'h040. bin_in=8'h80 -> neg=1, bcd_out=12'h128.
